// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: synchronizes an active-low raw key, debounces it and
// emits a clean level plus one-cycle press/release pulses.
//
// state        | meaning
// IDLE         | debounced released, watching for a press
// PRESS_WAIT   | key seen pressed, counting stable cycles before accepting
// PRESSED      | debounced pressed, watching for a release
// RELEASE_WAIT | key seen released, counting stable cycles before accepting
module key_debounce_pulse #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_key_level,
    output logic o_press_pulse,
    output logic o_release_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Sync chain resets to the released level so a held key looks like a fresh press.
    assign key_s = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q    <= '1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], i_key_n};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    level_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!key_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (key_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign o_key_level     = level_q;
    assign o_press_pulse   = press_q;
    assign o_release_pulse = release_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Scoreboard bench for key_debounce_pulse: stimulus queues expected pulse/level
// events with their cycle stamps, a negedge monitor checks what the DUT shows.
module tb_key_debounce_pulse;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_key_n;
    logic o_key_level;
    logic o_press_pulse;
    logic o_release_pulse;

    key_debounce_pulse #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_key_n        (i_key_n),
        .o_key_level    (o_key_level),
        .o_press_pulse  (o_press_pulse),
        .o_release_pulse(o_release_pulse)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int cyc;
        bit is_press;
    } ev_t;

    typedef struct {
        int cyc;
        bit val;
    } lev_t;

    ev_t  ev_q[$];
    lev_t lev_q[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit exp_level = 1'b0;
    int n_press = 0;
    int n_release = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Expected pulse is visible in the cycle after edge c, i.e. at the negedge where cyc==c.
    task automatic expect_press(input int c);
        ev_q.push_back('{cyc: c, is_press: 1'b1});
        lev_q.push_back('{cyc: c, val: 1'b1});
    endtask

    task automatic expect_release(input int c);
        ev_q.push_back('{cyc: c, is_press: 1'b0});
        lev_q.push_back('{cyc: c, val: 1'b0});
    endtask

    // Called just after a posedge; the first edge sampling v is cyc+1.
    task automatic hold(input bit v, input int n);
        i_key_n = v;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    always @(negedge i_clk) begin
        if (mon_en) begin
            while (lev_q.size() > 0 && lev_q[0].cyc <= cyc) begin
                exp_level = lev_q[0].val;
                void'(lev_q.pop_front());
            end
            checks++;
            if (o_key_level !== exp_level) begin
                errors++;
                $display("FAIL level cyc=%0d got=%b exp=%b", cyc, o_key_level, exp_level);
            end
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse cyc=%0d got=none exp=%s@%0d", cyc,
                         ev_q[0].is_press ? "press" : "release", ev_q[0].cyc);
                void'(ev_q.pop_front());
            end
            if (o_press_pulse === 1'b1 || o_release_pulse === 1'b1) begin
                if (o_press_pulse) n_press++;
                if (o_release_pulse) n_release++;
                checks++;
                if (o_press_pulse && o_release_pulse) begin
                    errors++;
                    $display("FAIL both_pulses cyc=%0d got=11 exp=one_hot", cyc);
                end else if (ev_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d got=%s exp=none", cyc,
                             o_press_pulse ? "press" : "release");
                end else begin
                    if (ev_q[0].cyc != cyc || ev_q[0].is_press != o_press_pulse) begin
                        errors++;
                        $display("FAIL pulse cyc=%0d got=%s exp=%s@%0d", cyc,
                                 o_press_pulse ? "press" : "release",
                                 ev_q[0].is_press ? "press" : "release", ev_q[0].cyc);
                    end
                    void'(ev_q.pop_front());
                end
            end else if (o_press_pulse !== 1'b0 || o_release_pulse !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL pulse_x cyc=%0d got=%b%b exp=known", cyc, o_press_pulse,
                         o_release_pulse);
            end
        end
    end

    initial begin
        int e;
        i_rst   = 1'b1;
        i_key_n = 1'b1;

        // Reset for 3 edges, then 20 idle cycles
        @(posedge i_clk);
        #1;
        mon_en = 1'b1;
        repeat (2) begin
            @(posedge i_clk);
            #1;
        end
        i_rst = 1'b0;
        hold(1'b1, 20);

        // Clean press with a long hold (no auto-repeat), then clean release
        e = cyc + 1;
        expect_press(e + 6);
        hold(1'b0, 40);
        e = cyc + 1;
        expect_release(e + 6);
        hold(1'b1, 12);

        // Bounce 0,1,0,1 then 0 held
        hold(1'b0, 1);
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 1);
        e = cyc + 1;
        expect_press(e + 6);
        hold(1'b0, 12);
        e = cyc + 1;
        expect_release(e + 6);
        hold(1'b1, 12);

        // 3-cycle low glitch while released
        hold(1'b0, 3);
        hold(1'b1, 12);

        // 3-cycle high glitch while pressed
        e = cyc + 1;
        expect_press(e + 6);
        hold(1'b0, 10);
        hold(1'b1, 3);
        hold(1'b0, 12);
        e = cyc + 1;
        expect_release(e + 6);
        hold(1'b1, 12);

        // Reset while in PRESS_WAIT with cnt=2, key kept held through reset
        hold(1'b0, 5);
        i_rst = 1'b1;
        hold(1'b0, 2);
        i_rst = 1'b0;
        e = cyc + 1;
        expect_press(e + 6);
        hold(1'b0, 12);
        e = cyc + 1;
        expect_release(e + 6);
        hold(1'b1, 12);

        // Back-to-back press/release cycles
        n_press = 0;
        n_release = 0;
        for (int i = 0; i < 10; i++) begin
            e = cyc + 1;
            expect_press(e + 6);
            hold(1'b0, 8);
            e = cyc + 1;
            expect_release(e + 6);
            hold(1'b1, 8);
        end
        hold(1'b1, 10);

        checks++;
        if (n_press != 10 || n_release != 10) begin
            errors++;
            $display("FAIL b2b_count got=%0d/%0d exp=10/10", n_press, n_release);
        end
        checks++;
        if (ev_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d exp=0", ev_q.size());
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
